// File: rtl/stream_mux_n.sv
// stream_mux_n
//   N-channel, WIDTH-bit registered stream multiplexer with valid/ready
//   handshaking. A channel is chosen either by an explicit index (sel) or by
//   an arbiter among valid inputs. A packet is locked once started: after a
//   non-last beat is accepted, only that channel is granted until its last
//   beat is accepted. One register stage sits between the inputs and the
//   consumer. It sustains one beat per cycle and supports back-pressure.
//
// Configuration macro:
//   STREAM_MUX_RR_EN  defined   : round-robin arbitration when arb_mode=1
//                     undefined : fixed priority, lowest index wins
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   arb_mode   0 = explicit select via sel, 1 = arbitrate among valid inputs
//   sel        channel index used when arb_mode=0 (values >= N select nothing)
//   in_valid   per-channel valid
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output register holds a beat
//   out_data   registered data
//   out_sel    index of the channel that produced out_data
//   out_last   registered last flag
//   out_ready  consumer accepts the beat
module stream_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_last,
  input  logic                 out_ready
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // N widened by one bit so that out-of-range sel values compare correctly
  localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

  state_t            state_r;
  state_t            state_s;
  logic [SELW-1:0]   lock_ch_r;
  logic              can_load_s;
  logic [SELW-1:0]   arb_idx_s;
  logic              arb_found_s;
  logic [SELW-1:0]   gidx_s;
  logic              grant_any_s;
  logic              accept_s;
  logic [WIDTH-1:0]  data_mux_s;
  logic              last_mux_s;

`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0]   rr_ptr_r;

  // Index base+k wrapped modulo N (k is always < N here)
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    return (sum >= N) ? SELW'(sum - N) : SELW'(sum);
  endfunction
`endif

  assign can_load_s = !out_valid || out_ready;

  // Arbiter: first valid channel in search order (rotating from rr_ptr, or from 0)
  always_comb begin
    arb_idx_s   = {SELW{1'b0}};
    arb_found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [SELW-1:0] cand;
`ifdef STREAM_MUX_RR_EN
      cand = wrap_add(rr_ptr_r, k);
`else
      cand = SELW'(k);
`endif
      // Only the first hit in search order is kept
      arb_idx_s   = (!arb_found_s && in_valid[cand]) ? cand : arb_idx_s;
      arb_found_s = arb_found_s | in_valid[cand];
    end
  end

  // Grant selection: locked channel wins, otherwise arbiter or explicit sel
  always_comb begin
    gidx_s      = {SELW{1'b0}};
    grant_any_s = 1'b0;
    if (state_r == ST_LOCKED) begin
      gidx_s      = lock_ch_r;
      grant_any_s = 1'b1;
    end else if (arb_mode) begin
      gidx_s      = arb_idx_s;
      grant_any_s = arb_found_s;
    end else begin
      gidx_s      = sel;
      grant_any_s = ({1'b0, sel} < N_EXT) && in_valid[sel];
    end
  end

  // Per-channel ready: one-hot on the granted channel when the register can load
  always_comb begin
    in_ready = {N{1'b0}};
    if (grant_any_s && can_load_s && !rst) begin
      in_ready[gidx_s] = 1'b1;
    end else begin
      in_ready = {N{1'b0}};
    end
  end

  assign accept_s   = grant_any_s && can_load_s && in_valid[gidx_s] && !rst;
  assign last_mux_s = in_last[gidx_s];

  // AND-OR data mux of the granted channel
  always_comb begin
    data_mux_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      data_mux_s = data_mux_s | ({WIDTH{gidx_s == SELW'(i)}} & in_data[i*WIDTH +: WIDTH]);
    end
  end

  // Packet-lock next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !last_mux_s) state_s = ST_LOCKED;
        else                         state_s = ST_IDLE;
      end
      ST_LOCKED: begin
        if (accept_s && last_mux_s) state_s = ST_IDLE;
        else                        state_s = ST_LOCKED;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Packet-lock state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Locked channel captured on the first beat of a multi-beat packet
  always_ff @(posedge clk) begin
    if (rst)                                         lock_ch_r <= {SELW{1'b0}};
    else if (state_r == ST_IDLE && state_s == ST_LOCKED) lock_ch_r <= gidx_s;
    else                                             lock_ch_r <= lock_ch_r;
  end

`ifdef STREAM_MUX_RR_EN
  // Round-robin pointer moves past the winner only when a beat ends in IDLE
  always_ff @(posedge clk) begin
    if (rst)                              rr_ptr_r <= {SELW{1'b0}};
    else if (accept_s && state_s == ST_IDLE) rr_ptr_r <= wrap_add(gidx_s, 1);
    else                                  rr_ptr_r <= rr_ptr_r;
  end
`endif

  // Output register: load replaces a draining beat in the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_sel   <= {SELW{1'b0}};
      out_last  <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_data  <= data_mux_s;
      out_sel   <= gidx_s;
      out_last  <= last_mux_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
